// File: rtl/mult_share_sched_if.sv
// ----------------------------------------------------------------------------
// mult_share_sched_if
// Bundles the request side and result side of the shared multiplier.
//   req/a/b     : per-client request and packed operands (client k at k*WIDTH)
//   gnt         : one-hot capture pulse back to the clients
//   busy        : scheduler is not idle
//   res_valid/res_ready/res/res_id : product return channel with owner tag
// Modports: master = clients plus result consumer, slave = the scheduler.
// ----------------------------------------------------------------------------
interface mult_share_sched_if #(
  parameter int WIDTH = 784,
  parameter int NREQ  = 2,
  parameter int IDW   = 1
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a;
  logic [NREQ*WIDTH-1:0] b;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  res_valid;
  logic                  res_ready;
  logic [2*WIDTH-1:0]    res;
  logic [IDW-1:0]        res_id;

  modport master (
    output req, a, b, res_ready,
    input  gnt, busy, res_valid, res, res_id
  );

  modport slave (
    input  req, a, b, res_ready,
    output gnt, busy, res_valid, res, res_id
  );
endinterface

// File: rtl/mult_share_sched.sv
// ----------------------------------------------------------------------------
// mult_share_sched
// Round-robin scheduler in front of one time-shared shift-add multiplier.
// A granted client's operands are captured, multiplied one multiplier bit per
// clock, and the 2*WIDTH product is returned tagged with the client index.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (aborts any job in flight)
//   bus  : mult_share_sched_if.slave (req/a/b in, gnt/busy/res* out, res_ready in)
// Configuration macro:
//   MULT_EARLY_TERM_EN : when defined, iteration stops once the remaining
//                        multiplier bits are all zero (variable latency).
// ----------------------------------------------------------------------------
module mult_share_sched #(
  parameter int WIDTH = 784,
  parameter int NREQ  = 2,
  parameter int IDW   = 1
) (
  input  logic               clk,
  input  logic               rst,
  mult_share_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_CNT  = CW'(WIDTH - 1);
  localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

  state_t               state_r;
  logic [IDW-1:0]       last_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [CW-1:0]        cnt_r;
  logic                 fin_r;
  logic [NREQ-1:0]      gnt_r;
  logic                 busy_r;
  logic                 res_valid_r;
  logic [2*WIDTH-1:0]   res_r;
  logic [IDW-1:0]       res_id_r;

  logic                 found_s;
  logic [IDW-1:0]       win_s;
  logic [WIDTH-1:0]     opa_s;
  logic [WIDTH-1:0]     opb_s;
  logic [2*WIDTH-1:0]   acc_next_s;
  logic                 last_iter_s;

  // Round-robin pick: first requester after the last winner, with wrap-around.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found_s && bus.req[(int'(last_r) + i) % NREQ]) begin
        found_s = 1'b1;
        win_s   = IDW'((int'(last_r) + i) % NREQ);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Operand mux for the current winner.
  always_comb begin
    opa_s = bus.a[int'(win_s)*WIDTH +: WIDTH];
    opb_s = bus.b[int'(win_s)*WIDTH +: WIDTH];
  end

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Flags the iteration that is the final one; the following edge publishes the result.
`ifdef MULT_EARLY_TERM_EN
  assign last_iter_s = (cnt_r == LAST_CNT) || (mplier_r[WIDTH-1:1] == '0);
`else
  assign last_iter_s = (cnt_r == LAST_CNT);
`endif

  // Scheduler FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      last_r      <= LAST_INIT;
      mcand_r     <= '0;
      mplier_r    <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      fin_r       <= 1'b0;
      gnt_r       <= '0;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
      res_r       <= '0;
      res_id_r    <= '0;
    end else begin
      // gnt is a single-cycle pulse following the capture edge
      gnt_r <= '0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            mcand_r  <= {{WIDTH{1'b0}}, opa_s};
            mplier_r <= opb_s;
            acc_r    <= '0;
            cnt_r    <= '0;
            fin_r    <= 1'b0;
            gnt_r    <= {{(NREQ-1){1'b0}}, 1'b1} << win_s;
            res_id_r <= win_s;
            last_r   <= win_s;
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end
        end
        RUN: begin
          if (fin_r) begin
            res_r       <= acc_r;
            res_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CW'(1);
            fin_r    <= last_iter_s;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.busy      = busy_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res       = res_r;
  assign bus.res_id    = res_id_r;

endmodule
